// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 memory access sequencer: state encoding and op flag.
package lc3_mem_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_WR_DATA   = 3'd1;
  localparam logic [STATE_W-1:0] S_WAIT      = 3'd2;
  localparam logic [STATE_W-1:0] S_RD_LATCH  = 3'd3;
  localparam logic [STATE_W-1:0] S_WR_COMMIT = 3'd4;
  localparam logic [STATE_W-1:0] S_DONE      = 3'd5;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // State that follows the wait window (or the address/data phase when there is none).
  function automatic logic [STATE_W-1:0] data_state(input op_e op);
    return (op == OP_WR) ? S_WR_COMMIT : S_RD_LATCH;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter: synchronous clear, count enable, terminal flag at TERM.
module mem_wait_counter #(
  parameter int CNT_W = 4,
  parameter int TERM  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic term
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign term = (count == CNT_W'(TERM));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory strobe sequencer: one read or write per request with programmable wait states.
module mem_access_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_rd,
  input  logic start_wr,
  output logic ldMAR,
  output logic ldMDR,
  output logic selMDR,
  output logic memWE,
  output logic bus_phase,
  output logic busy,
  output logic mem_ready,
  output logic req_err
);

  localparam int TERM = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;
  op_e                op;
  logic               idle;
  logic               start_any;
  logic               cnt_clear;
  logic               cnt_en;
  logic               cnt_term;

  assign idle      = (state == S_IDLE);
  assign start_any = start_rd | start_wr;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start_wr) begin
          next_state = S_WR_DATA;
        end else if (start_rd) begin
          next_state = (WAIT_CYCLES == 0) ? S_RD_LATCH : S_WAIT;
        end
      end
      S_WR_DATA:   next_state = (WAIT_CYCLES == 0) ? S_WR_COMMIT : S_WAIT;
      S_WAIT:      if (cnt_term) next_state = data_state(op);
      S_RD_LATCH:  next_state = S_DONE;
      S_WR_COMMIT: next_state = S_DONE;
      S_DONE:      next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // The counter restarts on every WAIT entry so each transaction gets the full window.
  assign cnt_clear = (next_state == S_WAIT) && (state != S_WAIT);
  assign cnt_en    = (state == S_WAIT);

  mem_wait_counter #(
    .CNT_W(CNT_W),
    .TERM (TERM)
  ) u_wait_counter (
    .clk  (clk),
    .reset(reset),
    .clear(cnt_clear),
    .en   (cnt_en),
    .term (cnt_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      op    <= OP_RD;
    end else begin
      state <= next_state;
      if (idle && start_any) begin
        op <= start_wr ? OP_WR : OP_RD;
      end
    end
  end

  // Address capture and request rejection are Mealy; everything else decodes state only.
  assign ldMAR     = idle & start_any;
  assign req_err   = start_any & (~idle | (start_rd & start_wr));
  assign ldMDR     = (state == S_WR_DATA) | (state == S_RD_LATCH);
  assign selMDR    = (state == S_RD_LATCH);
  assign bus_phase = (state == S_WR_DATA);
  assign memWE     = (state == S_WR_COMMIT);
  assign mem_ready = (state == S_DONE);
  assign busy      = ~idle;

endmodule
